// File: rtl/gate_pkg.sv
// gate_pkg: mode encodings and gate helper functions for the reduction pipe
package gate_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR} op_e;
  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  function automatic logic mode_legal(input logic [2:0] m);
    return m <= MODE_XNOR;
  endfunction
  function automatic op_e op_sel(input logic [2:0] m);
    return (m == MODE_AND || m == MODE_NAND) ? OP_AND :
           (m == MODE_OR  || m == MODE_NOR)  ? OP_OR  : OP_XOR;
  endfunction
  function automatic logic base_op(input logic [2:0] m, input logic a, input logic b);
    return op_sel(m) == OP_AND ? a & b : op_sel(m) == OP_OR ? a | b : a ^ b;
  endfunction
  function automatic logic invert(input logic [2:0] m);
    return m == MODE_NAND || m == MODE_NOR || m == MODE_XNOR;
  endfunction
endpackage

// File: rtl/gate_reduce_pipe_if.sv
// gate_reduce_pipe_if: input/output streams, error counter and status of the reduction pipe
interface gate_reduce_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_ref;
  logic [2:0]       out_mode;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;
  logic             mode_err;
  modport master (
    output in_valid, in_data, in_mode, out_ready, err_clr,
    input  in_ready, out_valid, out_bit, out_ref, out_mode, mismatch, err_cnt, mode_err
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready, err_clr,
    output in_ready, out_valid, out_bit, out_ref, out_mode, mismatch, err_cnt, mode_err
  );
endinterface

// File: rtl/gate_reduce_stage.sv
// gate_reduce_stage: one registered tree level halving its vector with the mode's base op
module gate_reduce_stage
  import gate_pkg::*;
#(
  parameter int IN_W = 2,
  parameter bit LAST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              in_valid,
  input  logic              in_ref,
  input  logic [2:0]        in_mode,
  input  logic [IN_W-1:0]   in_vec,
  output logic              out_valid,
  output logic              out_ref,
  output logic [2:0]        out_mode,
  output logic [IN_W/2-1:0] out_vec
);
  localparam int OW = IN_W / 2;
  logic [OW-1:0] red, fin, vec_d, vec_q;
  logic          valid_d, valid_q, ref_d, ref_q;
  logic [2:0]    mode_d, mode_q;
  // The last level owns the inversion and forces illegal modes to 0.
  always_comb begin
    red = '0;
    for (int i = 0; i < OW; i++) red[i] = base_op(in_mode, in_vec[2*i], in_vec[2*i+1]);
    fin = !LAST ? red : mode_legal(in_mode) ? red ^ {OW{invert(in_mode)}} : '0;
    vec_d = adv ? fin : vec_q;
    valid_d = adv ? in_valid : valid_q;
    ref_d = adv ? in_ref : ref_q;
    mode_d = adv ? in_mode : mode_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      valid_q <= 1'b0;
      ref_q <= 1'b0;
      mode_q <= '0;
    end else begin
      vec_q <= vec_d;
      valid_q <= valid_d;
      ref_q <= ref_d;
      mode_q <= mode_d;
    end
  end
  assign out_vec = vec_q;
  assign out_valid = valid_q;
  assign out_ref = ref_q;
  assign out_mode = mode_q;
endmodule

// File: rtl/gate_reduce_pipe.sv
// gate_reduce_pipe: pipelined N-input gate reduction checked against a behavioural result
module gate_reduce_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int LEVELS = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  gate_reduce_pipe_if.slave bus
);
  // Every tree level lives in one bus: level k (WIDTH>>k bits) starts at 2*WIDTH-2*(WIDTH>>k).
  logic [2*WIDTH-2:0]  tree;
  logic [LEVELS:0]     vld, rf;
  logic [LEVELS:0][2:0] md;
  logic adv, hs, tree_bit, mism, ref_base, ref_in;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic mode_err_d, mode_err_q;
  assign adv = !vld[LEVELS] || bus.out_ready;
  assign tree[WIDTH-1:0] = bus.in_data;
  assign vld[0] = bus.in_valid;
  assign md[0] = bus.in_mode;
  assign rf[0] = ref_in;
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW = WIDTH >> k;
    localparam int OI = 2*WIDTH - 2*IW;
    gate_reduce_stage #(.IN_W(IW), .LAST(k == LEVELS-1)) u_stage (
      .clk(clk), .rst(rst), .adv(adv),
      .in_valid(vld[k]), .in_ref(rf[k]), .in_mode(md[k]), .in_vec(tree[OI +: IW]),
      .out_valid(vld[k+1]), .out_ref(rf[k+1]), .out_mode(md[k+1]), .out_vec(tree[OI+IW +: IW/2])
    );
  end
  assign tree_bit = tree[2*WIDTH-2];
  assign hs = vld[LEVELS] && bus.out_ready;
  assign mism = vld[LEVELS] && (tree_bit != rf[LEVELS]);
  always_comb begin
    ref_base = op_sel(bus.in_mode) == OP_AND ? &bus.in_data :
               op_sel(bus.in_mode) == OP_OR  ? |bus.in_data : ^bus.in_data;
    ref_in = mode_legal(bus.in_mode) && (ref_base ^ invert(bus.in_mode));
    err_cnt_d = bus.err_clr ? '0 : (hs && mism && ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
    mode_err_d = mode_err_q || (bus.in_valid && adv && !mode_legal(bus.in_mode));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      mode_err_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      mode_err_q <= mode_err_d;
    end
  end
  assign bus.in_ready = adv;
  assign bus.out_valid = vld[LEVELS];
  assign bus.out_bit = tree_bit;
  assign bus.out_ref = rf[LEVELS];
  assign bus.out_mode = md[LEVELS];
  assign bus.mismatch = mism;
  assign bus.err_cnt = err_cnt_q;
  assign bus.mode_err = mode_err_q;
endmodule

// File: tb/tb_gate_reduce_pipe.sv
// tb_gate_reduce_pipe: directed checks of the 8-input pipe, plus a 2-bit counter copy for saturation
module tb_gate_reduce_pipe;
  import gate_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0, checks = 0, n_out = 0, n0;
  bit sb_en = 1'b1;
  logic [3:0] sbq [$];
  logic [3:0] sb_e;
  logic [7:0] sw_dat [3];
  logic [2:0] sw_exp [6];
  gate_reduce_pipe_if #(.WIDTH(8), .CNT_W(8)) b8 ();
  gate_reduce_pipe_if #(.WIDTH(8), .CNT_W(2)) b2 ();
  gate_reduce_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  gate_reduce_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  assign b2.in_valid = b8.in_valid;
  assign b2.in_data = b8.in_data;
  assign b2.in_mode = b8.in_mode;
  assign b2.out_ready = b8.out_ready;
  assign b2.err_clr = b8.err_clr;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // One cycle: drive at the falling edge, then score what the next rising edge will do.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] m,
                     input logic rdy, input logic clr, input logic e);
    @(negedge clk);
    b8.in_valid = v;
    b8.in_data = d;
    b8.in_mode = m;
    b8.out_ready = rdy;
    b8.err_clr = clr;
    #1;
    if (sb_en && b8.out_valid && b8.out_ready) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        sb_e = sbq.pop_front();
        check("sb_bit", b8.out_bit, sb_e[3]);
        check("sb_ref", b8.out_ref, sb_e[3]);
        check("sb_mode", b8.out_mode, sb_e[2:0]);
        check("sb_mism", b8.mismatch, 0);
        n_out++;
      end
    end
    if (sb_en && b8.in_valid && b8.in_ready) sbq.push_back({e, m});
  endtask
  initial begin
    sw_dat = '{8'hFF, 8'h00, 8'h01};
    sw_exp = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};
    b8.in_valid = 0; b8.in_data = 0; b8.in_mode = 0; b8.out_ready = 0; b8.err_clr = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ovalid", b8.out_valid, 0);
    check("rst_bit", b8.out_bit, 0);
    check("rst_ref", b8.out_ref, 0);
    check("rst_mode", b8.out_mode, 0);
    check("rst_err", b8.err_cnt, 0);
    check("rst_moderr", b8.mode_err, 0);
    check("rst_iready", b8.in_ready, 1);
    rst = 0;
    // OR of 00 then 10: results in cycles 3 and 4 after accept
    cyc(1, 8'h00, MODE_OR, 1, 0, 0); check("t1_ov0", b8.out_valid, 0);
    cyc(1, 8'h10, MODE_OR, 1, 0, 1); check("t1_ov1", b8.out_valid, 0);
    cyc(0, 8'h00, MODE_OR, 1, 0, 0); check("t1_ov2", b8.out_valid, 0);
    cyc(0, 8'h00, MODE_OR, 1, 0, 0); check("t1_ov3", b8.out_valid, 1); check("t1_bit3", b8.out_bit, 0);
    cyc(0, 8'h00, MODE_OR, 1, 0, 0); check("t1_ov4", b8.out_valid, 1); check("t1_bit4", b8.out_bit, 1);
    cyc(0, 8'h00, MODE_OR, 1, 0, 0); check("t1_ov5", b8.out_valid, 0); check("t1_err", b8.err_cnt, 0);
    // all six modes over FF/00/01
    for (int m = 0; m < 6; m++)
      for (int j = 0; j < 3; j++) cyc(1, sw_dat[j], 3'(m), 1, 0, sw_exp[m][j]);
    repeat (4) cyc(0, 8'h00, 0, 1, 0, 0);
    check("t2_drain", sbq.size(), 0);
    check("t2_count", n_out, 20);
    // five beats with a 4-cycle output stall
    n0 = n_out;
    cyc(1, 8'hFF, MODE_AND, 1, 0, 1);
    cyc(1, 8'h00, MODE_OR, 1, 0, 0);
    cyc(1, 8'h03, MODE_XOR, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'h0F, MODE_NAND, 0, 0, 1);
      check("t3_iready", b8.in_ready, 0);
      check("t3_ovalid", b8.out_valid, 1);
      check("t3_hold_bit", b8.out_bit, 1);
      check("t3_hold_mode", b8.out_mode, MODE_AND);
    end
    cyc(1, 8'h0F, MODE_NAND, 1, 0, 1);
    cyc(1, 8'h80, MODE_NOR, 1, 0, 0);
    repeat (6) cyc(0, 8'h00, 0, 1, 0, 0);
    check("t3_count", n_out - n0, 5);
    check("t3_drain", sbq.size(), 0);
    // illegal mode
    check("t4_moderr0", b8.mode_err, 0);
    cyc(1, 8'hFF, 3'd6, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t4_moderr1", b8.mode_err, 1);
    cyc(0, 8'h00, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0, 0);
    check("t4_ov", b8.out_valid, 1); check("t4_bit", b8.out_bit, 0);
    check("t4_ref", b8.out_ref, 0); check("t4_mode", b8.out_mode, 6);
    repeat (3) cyc(0, 8'h00, 0, 1, 0, 0);
    check("t4_sticky", b8.mode_err, 1);
    check("t4_err", b8.err_cnt, 0);
    // forced tree mismatches, clear wins on the third
    sb_en = 0;
    force dut8.tree_bit = 1'b0;
    repeat (3) cyc(1, 8'hFF, MODE_AND, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t5_mism", b8.mismatch, 1); check("t5_err0", b8.err_cnt, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t5_err1", b8.err_cnt, 1);
    cyc(0, 8'h00, 0, 1, 1, 0); check("t5_err2", b8.err_cnt, 2);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t5_clr", b8.err_cnt, 0); check("t5_ov", b8.out_valid, 0);
    check("t5_w2_clean", b2.err_cnt, 0);
    release dut8.tree_bit;
    force dut8.tree_bit = 1'b0;
    force dut2.tree_bit = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(i < 5, 8'hFF, MODE_AND, 1, 0, 0);
      if (i >= 4) check("t5_sat", b2.err_cnt, (i - 3 > 3) ? 3 : i - 3);
    end
    check("t5_err5", b8.err_cnt, 5);
    release dut8.tree_bit;
    release dut2.tree_bit;
    // reset with three beats in flight
    repeat (3) cyc(1, 8'hFF, MODE_AND, 1, 0, 0);
    @(negedge clk);
    rst = 1; b8.in_valid = 0; b8.out_ready = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("t6_ov", b8.out_valid, 0); check("t6_iready", b8.in_ready, 1);
    check("t6_moderr", b8.mode_err, 0); check("t6_err", b8.err_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0, 1, 0, 0);
      check("t6_flushed", b8.out_valid, 0);
    end
    cyc(1, 8'h01, MODE_XOR, 1, 0, 0); check("t6_lat0", b8.out_valid, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t6_lat1", b8.out_valid, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t6_lat2", b8.out_valid, 0);
    cyc(0, 8'h00, 0, 1, 0, 0); check("t6_lat3", b8.out_valid, 1);
    check("t6_bit", b8.out_bit, 1); check("t6_mode", b8.out_mode, MODE_XOR);
    check("t6_ref", b8.out_ref, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
